// File: rtl/access_router_pkg.sv
// Shared types and elaboration helpers for the access router: state set,
// timer sizing and parameter legality.
package access_router_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    DENIED  = 3'd2,
    GRANTED = 3'd3,
    ROUTE   = 3'd4,
    LOCKED  = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The timer only ever holds load values of LOCK_CYCLES-1 or HOLD_CYCLES-1.
  function automatic int timer_width(input int lock_cycles, input int hold_cycles);
    int m;
    m = max_int(lock_cycles, hold_cycles);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic bit cfg_legal(input int pass_w, input int data_w,
                                   input int num_ch, input int ch_w,
                                   input int max_tries, input int lock_cycles,
                                   input int hold_cycles);
    bit ok;
    ok = 1'b1;
    if (pass_w < 1) ok = 1'b0;
    if (num_ch < 2 || num_ch > 16) ok = 1'b0;
    if (ch_w < 1 || ch_w > data_w || ch_w > 30) ok = 1'b0;
    else if ((1 << ch_w) < num_ch) ok = 1'b0;
    if (max_tries < 1 || max_tries > 15) ok = 1'b0;
    if (lock_cycles < 1 || hold_cycles < 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/access_router_fsm_edge_pulse.sv
// Rising-edge detector: one-cycle pulse when sig goes from 0 to 1.
// Reusable for any synchronous button level.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic sig_d_r;

  // Previous-cycle copy of the input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_d_r <= 1'b0;
    end else begin
      sig_d_r <= sig;
    end
  end

  assign pulse = sig & ~sig_d_r;

endmodule

// File: rtl/access_router_fsm.sv
// Code-gated channel router: code check with lockout after repeated
// failures, then a timed one-hot enable on the selected channel.
module access_router_fsm
  import access_router_pkg::*;
#(
  parameter int PASS_W      = 4,
  parameter int DATA_W      = 4,
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              request,
  input  logic              confirm,
  input  logic [PASS_W-1:0] orginal_pass,
  input  logic [PASS_W-1:0] pass_data,
  input  logic [DATA_W-1:0] din,
  output logic [NUM_CH-1:0] en,
  output logic [DATA_W-1:0] dout,
  output logic              granted,
  output logic              locked,
  output logic              ch_err,
  output logic [3:0]        fail_cnt
);

  if (!cfg_legal(PASS_W, DATA_W, NUM_CH, CH_W, MAX_TRIES, LOCK_CYCLES, HOLD_CYCLES)) begin : g_bad_cfg
    $error("access_router_fsm: illegal parameter combination");
  end

  localparam int TW = timer_width(LOCK_CYCLES, HOLD_CYCLES);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ENTRY   = ENTRY;
  localparam logic [2:0] S_DENIED  = DENIED;
  localparam logic [2:0] S_GRANTED = GRANTED;
  localparam logic [2:0] S_ROUTE   = ROUTE;
  localparam logic [2:0] S_LOCKED  = LOCKED;

  localparam logic [TW-1:0]     LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0]     HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]     TIMER_ONE = TW'(1);
  localparam logic [3:0]        MAX_CNT   = 4'(MAX_TRIES);
  localparam logic [31:0]       NUM_CH_U  = 32'(NUM_CH);
  localparam logic [NUM_CH-1:0] EN_LSB    = {{(NUM_CH-1){1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [TW-1:0]     timer_r;
  logic              cev_s;
  logic              valid_s;
  logic              ch_ok_s;
  logic [CH_W-1:0]   ch_s;
  logic [3:0]        fail_inc_s;

  logic [2:0]        state_n;
  logic [TW-1:0]     timer_n;
  logic [NUM_CH-1:0] en_n;
  logic [DATA_W-1:0] dout_n;
  logic [3:0]        fail_n;
  logic              ch_err_n;
  logic              granted_n;
  logic              locked_n;

  edge_pulse u_confirm_edge (
    .clk   (CLK),
    .rst_n (RST),
    .sig   (confirm),
    .pulse (cev_s)
  );

  assign valid_s    = state_r inside {S_IDLE, S_ENTRY, S_DENIED, S_GRANTED, S_ROUTE, S_LOCKED};
  assign ch_s       = din[CH_W-1:0];
  assign ch_ok_s    = 32'(ch_s) < NUM_CH_U;
  assign fail_inc_s = (fail_cnt >= MAX_CNT) ? MAX_CNT : fail_cnt + 4'd1;

  // Next state and next registered output values.
  always_comb begin
    state_n  = state_r;
    timer_n  = timer_r;
    en_n     = en;
    dout_n   = dout;
    fail_n   = fail_cnt;
    ch_err_n = 1'b0;

    if (!valid_s) begin
      state_n = S_IDLE;
      timer_n = '0;
      en_n    = '0;
      dout_n  = '0;
      fail_n  = 4'd0;
    end else if (state_r == S_LOCKED) begin
      // Lockout runs to completion regardless of request or confirm.
      en_n = '0;
      if (timer_r == '0) begin
        state_n = S_IDLE;
        fail_n  = 4'd0;
      end else begin
        timer_n = timer_r - TIMER_ONE;
      end
    end else if (!request) begin
      state_n = S_IDLE;
      en_n    = '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_n = S_ENTRY;
        end
        S_ENTRY: begin
          if (!cev_s) begin
            state_n = S_ENTRY;
          end else if (pass_data == orginal_pass) begin
            state_n = S_GRANTED;
            fail_n  = 4'd0;
          end else begin
            fail_n = fail_inc_s;
            if (fail_inc_s == MAX_CNT) begin
              state_n = S_LOCKED;
              timer_n = LOCK_LOAD;
            end else begin
              state_n = S_DENIED;
            end
          end
        end
        S_DENIED: begin
          if (cev_s) begin
            state_n = S_ENTRY;
          end else begin
            state_n = S_DENIED;
          end
        end
        S_GRANTED: begin
          if (!cev_s) begin
            state_n = S_GRANTED;
          end else if (ch_ok_s) begin
            state_n = S_ROUTE;
            dout_n  = din;
            en_n    = EN_LSB << ch_s;
            timer_n = HOLD_LOAD;
          end else begin
            ch_err_n = 1'b1;
          end
        end
        S_ROUTE: begin
          if (timer_r == '0) begin
            state_n = S_GRANTED;
            en_n    = '0;
          end else begin
            timer_n = timer_r - TIMER_ONE;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end

    granted_n = (state_n == S_GRANTED) || (state_n == S_ROUTE);
    locked_n  = (state_n == S_LOCKED);
  end

  // State, timer and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= S_IDLE;
      timer_r  <= '0;
      en       <= '0;
      dout     <= '0;
      granted  <= 1'b0;
      locked   <= 1'b0;
      ch_err   <= 1'b0;
      fail_cnt <= 4'd0;
    end else begin
      state_r  <= state_n;
      timer_r  <= timer_n;
      en       <= en_n;
      dout     <= dout_n;
      granted  <= granted_n;
      locked   <= locked_n;
      ch_err   <= ch_err_n;
      fail_cnt <= fail_n;
    end
  end

endmodule

// File: tb/tb_access_router_fsm.sv
// Directed bench for access_router_fsm: two configurations (2 channels / 4-bit
// select, and 3 channels / 2-bit select) share stimulus and a behavioural model.
module tb_access_router_fsm;

  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int HOLD_CYCLES = 8;

  localparam int P_IDLE = 0, P_ENTRY = 1, P_DENIED = 2, P_GRANTED = 3, P_ROUTE = 4, P_LOCKED = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       request = 1'b0;
  logic       confirm = 1'b0;
  logic [3:0] orginal_pass = 4'hA;
  logic [3:0] pass_data = 4'h0;
  logic [3:0] din = 4'h0;

  logic [1:0] en_a;
  logic [3:0] dout_a, fail_a;
  logic       granted_a, locked_a, ch_err_a;
  logic [2:0] en_b;
  logic [3:0] dout_b, fail_b;
  logic       granted_b, locked_b, ch_err_b;

  int tests = 0;
  int fails = 0;

  // Behavioural model state, one slot per configuration.
  int m_phase [2];
  int m_left  [2];
  int m_en    [2];
  int m_dout  [2];
  int m_fail  [2];
  int m_cherr [2];
  bit m_prev;

  access_router_fsm dut_a (
    .CLK(CLK), .RST(RST), .request(request), .confirm(confirm),
    .orginal_pass(orginal_pass), .pass_data(pass_data), .din(din),
    .en(en_a), .dout(dout_a), .granted(granted_a), .locked(locked_a),
    .ch_err(ch_err_a), .fail_cnt(fail_a)
  );

  access_router_fsm #(.NUM_CH(3), .CH_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .request(request), .confirm(confirm),
    .orginal_pass(orginal_pass), .pass_data(pass_data), .din(din),
    .en(en_b), .dout(dout_b), .granted(granted_b), .locked(locked_b),
    .ch_err(ch_err_b), .fail_cnt(fail_b)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_IDLE;
      m_left[k]  = 0;
      m_en[k]    = 0;
      m_dout[k]  = 0;
      m_fail[k]  = 0;
      m_cherr[k] = 0;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_step();
    bit cev;
    int ch, nch, chw;
    cev    = confirm && !m_prev;
    m_prev = confirm;
    for (int k = 0; k < 2; k++) begin
      nch = (k == 0) ? 2 : 3;
      chw = (k == 0) ? 4 : 2;
      m_cherr[k] = 0;
      if (m_phase[k] == P_LOCKED) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_phase[k] = P_IDLE;
          m_fail[k]  = 0;
        end
      end else if (!request) begin
        m_phase[k] = P_IDLE;
        m_en[k]    = 0;
      end else begin
        case (m_phase[k])
          P_IDLE: m_phase[k] = P_ENTRY;
          P_ENTRY: if (cev) begin
            if (pass_data == orginal_pass) begin
              m_phase[k] = P_GRANTED;
              m_fail[k]  = 0;
            end else begin
              m_fail[k] = (m_fail[k] + 1 > MAX_TRIES) ? MAX_TRIES : m_fail[k] + 1;
              if (m_fail[k] == MAX_TRIES) begin
                m_phase[k] = P_LOCKED;
                m_left[k]  = LOCK_CYCLES;
              end else begin
                m_phase[k] = P_DENIED;
              end
            end
          end
          P_DENIED: if (cev) m_phase[k] = P_ENTRY;
          P_GRANTED: if (cev) begin
            ch = int'(din) % (1 << chw);
            if (ch < nch) begin
              m_phase[k] = P_ROUTE;
              m_dout[k]  = int'(din);
              m_en[k]    = 1 << ch;
              m_left[k]  = HOLD_CYCLES;
            end else begin
              m_cherr[k] = 1;
            end
          end
          P_ROUTE: begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_phase[k] = P_GRANTED;
              m_en[k]    = 0;
            end
          end
          default: m_phase[k] = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    bit ga, gb;
    ga = (m_phase[0] == P_GRANTED) || (m_phase[0] == P_ROUTE);
    gb = (m_phase[1] == P_GRANTED) || (m_phase[1] == P_ROUTE);
    check("A en",       32'(en_a),      32'(m_en[0]));
    check("A dout",     32'(dout_a),    32'(m_dout[0]));
    check("A granted",  32'(granted_a), 32'(ga));
    check("A locked",   32'(locked_a),  32'(m_phase[0] == P_LOCKED));
    check("A ch_err",   32'(ch_err_a),  32'(m_cherr[0]));
    check("A fail_cnt", 32'(fail_a),    32'(m_fail[0]));
    check("B en",       32'(en_b),      32'(m_en[1]));
    check("B dout",     32'(dout_b),    32'(m_dout[1]));
    check("B granted",  32'(granted_b), 32'(gb));
    check("B locked",   32'(locked_b),  32'(m_phase[1] == P_LOCKED));
    check("B ch_err",   32'(ch_err_b),  32'(m_cherr[1]));
    check("B fail_cnt", 32'(fail_b),    32'(m_fail[1]));
  endtask

  // One clock: model follows the sampling edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (!RST) model_reset();
    else model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic press();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    model_reset();

    // Reset state
    tick();
    check("reset en", 32'(en_a), 32'h0);
    check("reset fail_cnt", 32'(fail_a), 32'h0);
    tick();
    RST = 1'b1;
    tick();

    // Correct code, route channel 1 for the hold time
    request = 1'b1; pass_data = 4'hA;
    tick();
    confirm = 1'b1; tick();
    check("grant after match", 32'(granted_a), 32'h1);
    confirm = 1'b0; din = 4'h1; tick();
    confirm = 1'b1; tick();
    check("route en A", 32'(en_a), 32'h2);
    check("route en B", 32'(en_b), 32'h2);
    check("route dout", 32'(dout_a), 32'h1);
    confirm = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) confirm = 1'b1;
      tick();
      check("en held", 32'(en_a), 32'h2);
    end
    confirm = 1'b0;
    tick();
    check("en released", 32'(en_a), 32'h0);
    check("granted after hold", 32'(granted_a), 32'h1);
    request = 1'b0; tick();

    // Lockout after three mismatches
    request = 1'b1; pass_data = 4'h3; tick();
    press();
    check("fail 1", 32'(fail_a), 32'h1);
    press();
    press();
    check("fail 2", 32'(fail_a), 32'h2);
    press();
    confirm = 1'b1; tick();
    check("locked on 3rd", 32'(locked_a), 32'h1);
    check("fail 3", 32'(fail_a), 32'h3);
    confirm = 1'b0;
    cnt = 1;
    for (int i = 0; i < 40 && locked_a; i++) begin
      request = i[0];
      confirm = i[1];
      tick();
      if (locked_a) cnt++;
    end
    check("locked cycles", 32'(cnt), 32'd16);
    check("fail cleared", 32'(fail_a), 32'h0);
    request = 1'b0; confirm = 1'b0; tick();

    // Held confirm counts once
    request = 1'b1; pass_data = 4'h3; tick();
    confirm = 1'b1;
    repeat (10) tick();
    check("held confirm fail", 32'(fail_a), 32'h1);
    confirm = 1'b0; request = 1'b0; tick();

    // Out-of-range channel on B, then channel 2
    request = 1'b1; pass_data = 4'hA; tick();
    press();
    din = 4'h3; confirm = 1'b1; tick();
    check("B ch_err pulse", 32'(ch_err_b), 32'h1);
    check("B en on err", 32'(en_b), 32'h0);
    check("B stays granted", 32'(granted_b), 32'h1);
    confirm = 1'b0; tick();
    check("B ch_err cleared", 32'(ch_err_b), 32'h0);
    din = 4'h2; confirm = 1'b1; tick();
    check("B en ch2", 32'(en_b), 32'h4);
    check("A ch2 out of range", 32'(ch_err_a), 32'h1);
    confirm = 1'b0; request = 1'b0; tick();

    // Request drop on the 3rd hold cycle
    request = 1'b1; pass_data = 4'hA; tick();
    press();
    din = 4'h9; confirm = 1'b1; tick();
    confirm = 1'b0; tick(); tick();
    check("B en before drop", 32'(en_b), 32'h2);
    request = 1'b0; tick();
    check("B en after drop", 32'(en_b), 32'h0);
    check("B dout retained", 32'(dout_b), 32'h9);
    check("B granted after drop", 32'(granted_b), 32'h0);

    // Asynchronous reset in the middle of a lockout
    request = 1'b1; pass_data = 4'h3; tick();
    press(); press(); press(); press();
    confirm = 1'b1; tick();
    confirm = 1'b0;
    repeat (8) tick();
    check("locked before reset", 32'(locked_a), 32'h1);
    #2 RST = 1'b0;
    model_reset();
    #1;
    check("async locked", 32'(locked_a), 32'h0);
    check("async fail_cnt", 32'(fail_a), 32'h0);
    check("async en", 32'(en_b), 32'h0);
    check("async locked B", 32'(locked_b), 32'h0);
    compare_all();
    tick();
    RST = 1'b1; request = 1'b1; pass_data = 4'hA;
    tick();
    press();
    check("grant after reset", 32'(granted_a), 32'h1);
    request = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
